// File: rtl/core_mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// core_mem_access_unit_pkg
//   Shared encodings for the memory-access stage:
//     - access size encodings (byte / half / word)
//     - FSM state encoding (3 bits)
//     - timeout counter width
//     - misalignment helper used by the FSM on request acceptance
// -----------------------------------------------------------------------------
package core_mem_access_unit_pkg;

    localparam int LANE_DATA_W = 32;
    localparam int CNT_W       = 8;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } mau_state_e;

    // Size 3 has no meaning and is rejected the same way as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = addr_lo[0];
            SIZE_W:  mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/core_mem_access_unit_lane.sv
// -----------------------------------------------------------------------------
// core_mem_access_unit_lane
//   Purely combinational byte-lane logic.
//   Store path: size + addr_lo -> byte enables, replicated store data.
//   Load path : raw read word + size + addr_lo + unsigned -> extended data.
//
// Ports:
//   size        in  2   access size (SIZE_B/H/W)
//   addr_lo     in  2   byte offset within the word
//   is_unsigned in  1   zero-extend loads
//   wdata       in  32  store value in its low bits
//   rdata       in  32  raw bus read word
//   be          out 4   byte enables
//   wdata_lane  out 32  store data replicated into every candidate lane
//   rdata_ext   out 32  selected lane shifted down and extended
// -----------------------------------------------------------------------------
module core_mem_access_unit_lane
    import core_mem_access_unit_pkg::*;
(
    input  logic [1:0]             size,
    input  logic [1:0]             addr_lo,
    input  logic                   is_unsigned,
    input  logic [LANE_DATA_W-1:0] wdata,
    input  logic [LANE_DATA_W-1:0] rdata,
    output logic [3:0]             be,
    output logic [LANE_DATA_W-1:0] wdata_lane,
    output logic [LANE_DATA_W-1:0] rdata_ext
);

    logic [LANE_DATA_W-1:0] rdata_shift;

    always_comb begin
        be         = 4'b0000;
        wdata_lane = '0;
        case (size)
            SIZE_B: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                be         = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
            end
            SIZE_W: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
            default: begin
                be         = 4'b0000;
                wdata_lane = '0;
            end
        endcase
    end

    // Aligned word loads have addr_lo=0, so the shift is a pass-through for them.
    assign rdata_shift = rdata >> {addr_lo, 3'b000};

    always_comb begin
        rdata_ext = rdata_shift;
        case (size)
            SIZE_B:  rdata_ext = {{24{~is_unsigned & rdata_shift[7]}},  rdata_shift[7:0]};
            SIZE_H:  rdata_ext = {{16{~is_unsigned & rdata_shift[15]}}, rdata_shift[15:0]};
            default: rdata_ext = rdata_shift;
        endcase
    end

endmodule

// File: rtl/core_mem_access_unit.sv
// -----------------------------------------------------------------------------
// core_mem_access_unit
//   Memory-access stage behind the execution unit. Runs one load/store at a
//   time on a req/gnt/rvalid data bus, holds the pipeline with stall_o while
//   busy, and returns a one-cycle response to write-back.
//
// Handshakes:
//   EX side : a request is taken on a rising edge where req_valid_i=1 and
//             req_ready_o=1 (only in IDLE); req_valid_i elsewhere is ignored.
//   Bus side: mem_req_o and its attributes stay stable until a cycle with
//             mem_gnt_i=1; mem_rvalid_i is only looked at from the cycle after
//             the grant onward.
//   WB side : rsp_valid_o is a single-cycle pulse, rsp_err_o/rsp_data_o are
//             meaningful only with it.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid_i/req_ready_o          EX request handshake
//   req_we_i, req_size_i,
//   req_unsigned_i, req_addr_i,
//   req_wdata_i                      request attributes
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_be_o, mem_wdata_o            bus request (driven only in REQ)
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i                      bus response
//   rsp_valid_o, rsp_data_o,
//   rsp_err_o                        write-back response
//   stall_o                          pipeline hold
//   dbg_state_o                      current FSM state
// -----------------------------------------------------------------------------
module core_mem_access_unit
    import core_mem_access_unit_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              stall_o,
    output logic [2:0]        dbg_state_o
);

    // Timeout fires on the last counted cycle so the bus sees exactly
    // TIMEOUT_CYC cycles of REQ (or WAIT) before the error response.
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC - 1);

    mau_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] load_q;

    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;
    logic              timeout_hit;
    logic              accept;

    core_mem_access_unit_lane u_lane (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (mem_rdata_i),
        .be          (lane_be),
        .wdata_lane  (lane_wdata),
        .rdata_ext   (lane_rdata)
    );

    assign timeout_hit = (cnt_q >= TIMEOUT_LIM);
    assign accept      = (state_q == ST_IDLE) && req_valid_i;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = '0;
        rsp_valid_o = 1'b0;
        rsp_data_o  = '0;
        rsp_err_o   = 1'b0;
        stall_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                stall_o     = req_valid_i;
                if (req_valid_i) begin
                    state_d = is_misaligned(req_size_i, req_addr_i[1:0]) ? ST_ERR : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_be_o    = lane_be;
                mem_wdata_o = lane_wdata;
                stall_o     = 1'b1;
                if (mem_gnt_i) begin
                    state_d = ST_WAIT;
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_WAIT: begin
                stall_o = 1'b1;
                if (mem_rvalid_i) begin
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_data_o  = we_q ? '0 : load_q;
                state_d     = ST_IDLE;
            end
            ST_ERR: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = 1'b1;
                stall_o     = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if ((state_q == ST_REQ || state_q == ST_WAIT) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (accept) begin
                we_q    <= req_we_i;
                size_q  <= req_size_i;
                uns_q   <= req_unsigned_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end

            if (state_q == ST_WAIT && mem_rvalid_i) begin
                load_q <= lane_rdata;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_core_mem_access_unit
//   Directed + randomized transactions against a cycle-level reference model
//   derived from the access rules (latency, lane placement, extension).
// -----------------------------------------------------------------------------
module tb_core_mem_access_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        stall_o;
    logic [2:0]  dbg_state_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    core_mem_access_unit #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_data_o     (rsp_data_o),
        .rsp_err_o      (rsp_err_o),
        .stall_o        (stall_o),
        .dbg_state_o    (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic logic model_misaligned(input logic [1:0] size, input logic [31:0] addr);
        int a;
        a = int'(addr % 4);
        return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && a != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v;
        int a;
        a = int'(addr % 4);
        v = rdata >> (8 * a);
        if (size == 2'd0) begin
            v = v & 32'h0000_00FF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = v & 32'h0000_FFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        int a;
        a = int'(addr % 4);
        if (size == 2'd0) return 4'(1 << a);
        if (size == 2'd1) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wdata);
        if (size == 2'd0) return (wdata & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (wdata & 32'hFFFF) * 32'h0001_0001;
        return wdata;
    endfunction

    // ---------------- driver: one full transaction ----------------
    // gd: REQ cycle index at which gnt is given (>= TO never grants)
    // rd: WAIT cycle index at which rvalid is given (>= TO never responds)
    // spur: also pulse rvalid in the grant cycle (must be ignored)
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int gd, input int rd,
                           input logic spur);
        logic        mis;
        logic        err;
        int          rsp_cyc;
        int          req_last;
        logic        exp_req;
        logic [31:0] exp_data;
        logic [31:0] got_data;

        mis = model_misaligned(size, addr);
        req_last = 0;
        if (mis) begin
            err = 1'b1; rsp_cyc = 1;
        end else if (gd >= TO) begin
            err = 1'b1; rsp_cyc = TO + 1; req_last = TO;
        end else if (rd >= TO) begin
            err = 1'b1; rsp_cyc = 2 + gd + TO; req_last = 1 + gd;
        end else begin
            err = 1'b0; rsp_cyc = 3 + gd + rd; req_last = 1 + gd;
        end
        exp_data = (err || we) ? 32'h0 : model_load(size, uns, addr, rdata);
        exp_q.push_back(exp_data);

        @(negedge clk);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        mem_rdata_i    = rdata;
        #1;
        check_eq("req_ready_idle", {31'b0, req_ready_o}, 32'd1);
        check_eq("stall_idle_valid", {31'b0, stall_o}, 32'd1);

        for (int c = 1; c <= rsp_cyc; c++) begin
            @(negedge clk);
            exp_req = !mis && (c <= req_last);
            check_eq("mem_req", {31'b0, mem_req_o}, {31'b0, exp_req});
            if (exp_req) begin
                check_eq("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
                check_eq("mem_be", {28'b0, mem_be_o}, {28'b0, model_be(size, addr)});
                check_eq("mem_we", {31'b0, mem_we_o}, {31'b0, we});
                if (we) check_eq("mem_wdata", mem_wdata_o, model_wdata(size, wdata));
            end
            check_eq("rsp_valid", {31'b0, rsp_valid_o}, (c == rsp_cyc) ? 32'd1 : 32'd0);
            check_eq("stall", {31'b0, stall_o}, (c == rsp_cyc) ? {31'b0, err} : 32'd1);
            if (c == rsp_cyc) begin
                got_data = rsp_data_o;
                check_eq("rsp_err", {31'b0, rsp_err_o}, {31'b0, err});
                check_eq("rsp_data", got_data, exp_q.pop_front());
            end
            req_valid_i  = 1'b0;
            mem_gnt_i    = !mis && (gd < TO) && (c == 1 + gd);
            mem_rvalid_i = (!mis && gd < TO && rd < TO && c == 2 + gd + rd) ||
                           (spur && !mis && gd < TO && c == 1 + gd);
        end
    endtask

    // Reset asserted mid-transaction; phase 1 = REQ, 2 = WAIT.
    task automatic reset_mid_txn(input int phase);
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2;
        req_unsigned_i = 1'b0; req_addr_i = 32'h40; req_wdata_i = 32'h0;
        mem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid_i = 1'b0;
        mem_gnt_i   = (phase == 2);
        if (phase == 2) begin
            @(negedge clk);
            mem_gnt_i = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_mem_req", {31'b0, mem_req_o}, 32'd0);
        check_eq("rst_mid_stall", {31'b0, stall_o}, 32'd0);
        check_eq("rst_mid_ready", {31'b0, req_ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_late_rsp", {31'b0, rsp_valid_o}, 32'd0);
            check_eq("rst_late_req", {31'b0, mem_req_o}, 32'd0);
        end
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0]  r_size;
        logic [31:0] r_addr;
        rst_n = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0; req_unsigned_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", {31'b0, req_ready_o}, 32'd1);
        check_eq("rst_stall", {31'b0, stall_o}, 32'd0);
        check_eq("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        check_eq("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check_eq("rst_rsp_data", rsp_data_o, 32'd0);
        check_eq("rst_be", {28'b0, mem_be_o}, 32'd0);
        rst_n = 1'b1;

        // directed cases
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0, 0, 1'b0);
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0, 0, 1'b0);
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1, 2, 1'b0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 32'h1111_1111, 0, 0, 1'b0);
        run_txn(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0, 32'h1111_1111, 0, 0, 1'b0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 32'h2222_2222, 10, 0, 1'b0);
        run_txn(1'b0, 2'd1, 1'b0, 32'h0000_0302, 32'h0, 32'h8001_7FFF, 1, 10, 1'b0);
        run_txn(1'b0, 2'd1, 1'b0, 32'h0000_0302, 32'h0, 32'h8001_7FFF, TO - 1, TO - 1, 1'b1);
        run_txn(1'b1, 2'd0, 1'b0, 32'h0000_0401, 32'hAAAA_5A3C, 32'h0, 0, 0, 1'b1);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            r_size = 2'($urandom_range(0, 3));
            r_addr = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                if (r_size == 2'd1) r_addr[0] = 1'b0;
                if (r_size == 2'd2) r_addr[1:0] = 2'b00;
            end
            run_txn(1'($urandom_range(0, 1)), r_size, 1'($urandom_range(0, 1)), r_addr,
                    $urandom(), $urandom(), $urandom_range(0, TO), $urandom_range(0, TO),
                    1'($urandom_range(0, 1)));
        end

        reset_mid_txn(1);
        reset_mid_txn(2);
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 32'h0BAD_CAFE, 0, 0, 1'b0);

        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
